// File: rtl/keccak_rho_seq.sv
// keccak_rho_seq
//   Sequential Keccak rho stage with optional pi lane permutation. A full
//   5x5 state of W-bit lanes is captured, then LPC lanes per cycle are
//   rotated in place over 25/LPC cycles. The result is then presented on
//   A_out until downstream takes it.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   A_in/pi_en hold a state to accept
//   in_ready   block accepts this cycle (no path from in_valid)
//   pi_en      sampled with the accepted state, 1 = apply pi after rho
//   A_in       input state, indexed [y][x]
//   out_valid  A_out holds a finished state
//   out_ready  downstream takes A_out this cycle
//   A_out      result state, indexed [y][x]
//
// States
//   IDLE | empty, waiting for a state
//   BUSY | rotating lane group cnt of the buffer
//   DONE | result presented, buffer frozen until out_ready
module keccak_rho_seq #(
  parameter int W   = 64,
  parameter int LPC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   pi_en,
  input  logic [0:4][0:4][W-1:0] A_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:4][0:4][W-1:0] A_out
);

  localparam int NG = 25 / LPC;
  localparam int CW = $clog2(NG + 1);
  localparam logic [CW-1:0] LAST = CW'(NG - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             st;
  logic [CW-1:0]      cnt;
  logic               pi_q;
  logic [24:0][W-1:0] lanes;
  logic [24:0][W-1:0] rot;

  // rho offsets for 64-bit lanes, lane index i = 5*y + x
  function automatic int rho_off(input int i);
    case (i)
      0:  return 0;   1:  return 1;   2:  return 62;  3:  return 28;  4:  return 27;
      5:  return 36;  6:  return 44;  7:  return 6;   8:  return 55;  9:  return 20;
      10: return 3;   11: return 10;  12: return 43;  13: return 25;  14: return 39;
      15: return 41;  16: return 45;  17: return 15;  18: return 21;  19: return 8;
      20: return 18;  21: return 2;   22: return 61;  23: return 56;  24: return 14;
      default: return 0;
    endcase
  endfunction

  // Left rotate: the upper half of the doubled lane shifted by r
  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int r);
    logic [2*W-1:0] d;
    d = {v, v} << r;
    return d[2*W-1:W];
  endfunction

  always_comb begin
    for (int i = 0; i < 25; i++) rot[i] = rotl(lanes[i], rho_off(i) % W);
  end

  assign in_ready = rst_n & ((st == IDLE) | ((st == DONE) & out_ready));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= IDLE;
      cnt       <= '0;
      lanes     <= '0;
      pi_q      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            for (int y = 0; y < 5; y++)
              for (int x = 0; x < 5; x++) lanes[5*y + x] <= A_in[y][x];
            pi_q <= pi_en;
            cnt  <= '0;
            st   <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 0; i < 25; i++)
            if (i / LPC == int'(cnt)) lanes[i] <= rot[i];
          if (cnt == LAST) begin
            cnt       <= '0;
            st        <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++) lanes[5*y + x] <= A_in[y][x];
              pi_q <= pi_en;
              cnt  <= '0;
              st   <= BUSY;
            end else begin
              st <= IDLE;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // pi sends buf[y][x] to out[(2x+3y)%5][y]; inverted, out[Y][X] reads
  // buf[X][(3Y+X)%5]
  for (genvar y = 0; y < 5; y++) begin : g_y
    for (genvar x = 0; x < 5; x++) begin : g_x
      assign A_out[y][x] = pi_q ? lanes[5*x + (3*y + x) % 5] : lanes[5*y + x];
    end
  end

endmodule

// File: tb/tb_keccak_rho_seq.sv
// Testbench for keccak_rho_seq: several parameterisations side by side, each
// with a driver that pushes the reference result into a queue on handshake and
// a monitor that pops and compares whenever a result is taken.
module tb_keccak_rho_seq;

  localparam int NI    = 6;
  localparam int WS [NI] = '{64, 32, 64, 64, 8, 16};
  localparam int LS [NI] = '{1, 5, 25, 5, 1, 25};
  localparam int RHO [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                              41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
  localparam int NRAND = 170;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [NI-1:0] done = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : u
    localparam int W   = WS[g];
    localparam int LPC = LS[g];
    localparam int NG  = 25 / LPC;
    typedef logic [0:4][0:4][W-1:0] st_t;

    logic rst_n, in_valid, in_ready, pi_en, out_valid, out_ready;
    bit   rnd_ready = 0;
    bit   dir_go = 0;
    bit   dir_done = 0;
    st_t  A_in, A_out, mon_e;
    st_t  exp_q[$];

    keccak_rho_seq #(.W(W), .LPC(LPC)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .pi_en(pi_en), .A_in(A_in), .out_valid(out_valid), .out_ready(out_ready),
      .A_out(A_out)
    );

    function automatic st_t model(input st_t s, input logic p);
      st_t r, o;
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++) begin
          int off;
          off = RHO[5*y + x] % W;
          for (int z = 0; z < W; z++) r[y][x][z] = s[y][x][(z - off + W) % W];
        end
      o = r;
      if (p)
        for (int y = 0; y < 5; y++)
          for (int x = 0; x < 5; x++) o[(2*x + 3*y) % 5][y] = r[y][x];
      return o;
    endfunction

    function automatic st_t rnd_state();
      st_t s;
      logic [63:0] v;
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++) begin
          v = {$urandom(), $urandom()};
          s[y][x] = v[W-1:0];
        end
      return s;
    endfunction

    task automatic send(input st_t s, input logic p);
      int n;
      bit ok;
      n = 0;
      ok = 0;
      A_in = s; pi_en = p; in_valid = 1'b1;
      while (!ok && n < 200) begin
        @(negedge clk);
        if (in_ready) ok = 1;
        else n++;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL u%0d_accept_timeout: in_ready stayed 0, expected 1 within 200 cycles", g);
        in_valid = 1'b0;
      end else begin
        exp_q.push_back(model(s, p));
        @(posedge clk); #1;
        in_valid = 1'b0; pi_en = ~p; A_in = rnd_state();
      end
    endtask

    // Called right after send: NG busy cycles, then out_valid
    task automatic latency(input string nm);
      for (int c = 0; c < NG; c++) begin
        @(negedge clk);
        chk({nm, "_busy_out_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_busy_in_ready"}, 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      chk({nm, "_done_out_valid"}, 64'(out_valid), 64'd1);
    endtask

    always begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    always begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL u%0d_unexpected_output: got out_valid=1 expected no pending state", g);
        end else begin
          mon_e = exp_q.pop_front();
          if (A_out !== mon_e) begin
            bit shown;
            shown = 0;
            errors++;
            for (int y = 0; y < 5; y++)
              for (int x = 0; x < 5; x++)
                if (!shown && A_out[y][x] !== mon_e[y][x]) begin
                  shown = 1;
                  $display("FAIL u%0d_state lane[%0d][%0d]: got %h expected %h",
                           g, y, x, A_out[y][x], mon_e[y][x]);
                end
          end
        end
      end
    end

    if (g == 0) begin : d
      initial begin
        st_t s;
        bit seen;
        wait (dir_go);
        s = '0; s[1][0] = 1;
        send(s, 1'b0);
        latency("impulse64");
        chk("impulse64_lane10", 64'(A_out[1][0]), 64'h0000_0010_0000_0000);
        s = A_out; s[1][0] = '0;
        chk("impulse64_others", 64'(|s), 64'd0);
        @(posedge clk); #1;
        send(rnd_state(), 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("midrst_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_a_out_zero", 64'(|A_out), 64'd0);
        seen = 0;
        repeat (30) begin
          @(negedge clk);
          if (out_valid) seen = 1;
        end
        chk("midrst_no_pulse", 64'(seen), 64'd0);
        @(posedge clk); #1;
        send(rnd_state(), 1'b1);
        latency("after_rst");
        dir_done = 1;
      end
    end else if (g == 1) begin : d
      initial begin
        st_t s;
        wait (dir_go);
        for (int y = 0; y < 5; y++)
          for (int x = 0; x < 5; x++) s[y][x] = 1;
        send(s, 1'b0);
        latency("ones32");
        chk("ones32_lane10", 64'(A_out[1][0]), 64'h10);
        chk("ones32_lane02", 64'(A_out[0][2]), 64'h4000_0000);
        chk("ones32_lane31", 64'(A_out[3][1]), 64'h2000);
        dir_done = 1;
      end
    end else if (g == 2) begin : d
      initial begin
        st_t s;
        wait (dir_go);
        s = '0; s[1][0] = 1; s[0][0] = 64'h0123_4567_89ab_cdef;
        send(s, 1'b1);
        latency("pi64");
        chk("pi64_lane31", 64'(A_out[3][1]), 64'h0000_0010_0000_0000);
        chk("pi64_lane10", 64'(A_out[1][0]), 64'd0);
        chk("pi64_lane00", 64'(A_out[0][0]), 64'h0123_4567_89ab_cdef);
        dir_done = 1;
      end
    end else if (g == 3) begin : d
      initial begin
        st_t s, e;
        bit bad;
        wait (dir_go);
        out_ready = 1'b0;
        s = rnd_state();
        e = model(s, 1'b1);
        send(s, 1'b1);
        latency("bp");
        bad = 0;
        repeat (10) begin
          @(negedge clk);
          chk("bp_out_valid", 64'(out_valid), 64'd1);
          chk("bp_in_ready", 64'(in_ready), 64'd0);
          if (A_out !== e) bad = 1;
        end
        chk("bp_a_out_stable", 64'(bad), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(rnd_state(), 1'b0);
        latency("bp_next");
        dir_done = 1;
      end
    end else begin : d
      initial begin
        wait (dir_go);
        dir_done = 1;
      end
    end

    initial begin
      int n;
      rst_n = 1'b0; in_valid = 1'b0; pi_en = 1'b0; A_in = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("u%0d_rst_in_ready", g), 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk($sformatf("u%0d_init_in_ready", g), 64'(in_ready), 64'd1);
      chk($sformatf("u%0d_init_out_valid", g), 64'(out_valid), 64'd0);
      chk($sformatf("u%0d_init_a_out", g), 64'(|A_out), 64'd0);
      @(posedge clk); #1;
      dir_go = 1;
      n = 0;
      while (!dir_done && n < 2000) begin
        @(posedge clk);
        n++;
      end
      chk($sformatf("u%0d_directed_done", g), 64'(dir_done), 64'd1);
      @(posedge clk); #1;
      rnd_ready = 1;
      repeat (NRAND) begin
        send(rnd_state(), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      rnd_ready = 0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
        @(posedge clk);
        n++;
      end
      @(negedge clk);
      chk($sformatf("u%0d_drain_pending", g), 64'(exp_q.size()), 64'd0);
      done[g] = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(&done) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (!(&done)) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: done=%b expected all ones", done);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/keccak_rho_seq.md
# keccak_rho_seq

Parametrised, sequential successor to the combinational Keccak ρ stage. It applies the ρ lane rotations, and optionally the π lane permutation, to a full 5×5 state of W-bit lanes. Lanes are processed LPC at a time over 25/LPC cycles, behind valid/ready handshakes on both sides. It sits between θ and χ in iterative Keccak-f[25·W] cores where area matters more than round latency.

## Interface
- W, 64: lane width; one of 8, 16, 32, 64.
- LPC, 1: lanes rotated per cycle; one of 1, 5, 25.
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  A_in holds a state to accept.
- in_ready  out  1  block can accept this cycle.
- pi_en  in  1  sampled with the accepted state; 1 = apply π after ρ.
- A_in  in  [W-1:0] [0:4][0:4]  input state, indexed [y][x].
- out_valid  out  1  A_out holds a finished state.
- out_ready  in  1  downstream takes A_out this cycle.
- A_out  out  [W-1:0] [0:4][0:4]  result, indexed [y][x].

## Operation
- Storage: one 25-lane buffer `buf[y][x]`, a latched `pi_q`, a lane counter `cnt` of width ceil(log2(25/LPC+1)), and state register `st`.
- ρ offsets for W=64, listed by row y=0..4, x=0..4:
  - y0: 0 1 62 28 27
  - y1: 36 44 6 55 20
  - y2: 3 10 43 25 39
  - y3: 41 45 15 21 8
  - y4: 18 2 61 56 14
- Effective rotation is offset mod W. Rotation is left (toward MSB): bit z of the result equals bit (z−r) mod W of the source.
- Lane linear index i = 5·y + x. The BUSY cycle with counter value c rotates lanes i = c·LPC … c·LPC+LPC−1 in place. All other lanes hold.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid: buf←A_in, pi_q←pi_en, cnt←0, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Rotate the current group and increment cnt. After the group with c = 25/LPC−1, go to DONE.
  - DONE: out_valid=1; buf frozen.
    - out_ready=1 with in_valid=1: load the new state and go to BUSY (back-to-back).
    - out_ready=1 with in_valid=0: go to IDLE.
    - out_ready=0: hold.
- in_ready = (st==IDLE) | (st==DONE & out_ready). It is combinational, with no combinational path from in_valid.
- A_out in DONE:
  - pi_q=0: A_out[y][x] = buf[y][x].
  - pi_q=1: A_out[(2x+3y) mod 5][y] = buf[y][x], which is π in [y][x] indexing.
- A_out outside DONE is don't-care, but it is driven by the same wiring from buf (no X).
- pi_en and A_in are ignored unless the handshake completes.

## Timing
- Reset values: st=IDLE, cnt=0, buf all-zero, pi_q=0, out_valid=0. in_ready reads 1 in the first cycle after reset deasserts and is 0 while rst_n=0.
- Latency: a handshake at edge k gives out_valid=1 from edge k+25/LPC.
  - LPC=1: 25 cycles.
  - LPC=5: 5 cycles.
  - LPC=25: 1 cycle.
- Throughput: one state per 25/LPC+1 cycles when out_ready is held high. The extra cycle is the DONE hand-off, which overlaps the next load.
- Backpressure: while out_valid=1 and out_ready=0, A_out and out_valid stay stable and in_ready=0.
- Reset mid-operation (BUSY or DONE with rst_n=0 at an edge): return to reset values. The in-flight state is discarded and no out_valid pulse is produced.
- cnt never exceeds 25/LPC−1. It is only meaningful in BUSY.

## Test plan
- W=64, LPC=1, pi_en=0, A_in[1][0]=64'h1 and all other lanes 0, handshake at edge k → out_valid rises at edge k+25 and A_out[1][0]=64'h0000_0010_0000_0000 (offset 36). All other lanes 0. in_ready=0 for edges k+1..k+24.
- W=32, LPC=5, pi_en=0, every lane 32'h1 → at edge k+5, A_out[y][x]=32'h1 rotated by (offset mod 32); e.g. [1][0]=32'h10, [0][2]=32'h4000_0000, [3][1]=32'h2000.
- W=64, LPC=25, pi_en=1, A_in[1][0]=64'h1 → at edge k+1, A_out[3][1]=64'h0000_0010_0000_0000 and A_out[1][0]=0. Lane [0][0] passes unrotated to [0][0].
- W=64, LPC=5, out_ready=0 for 10 cycles after out_valid → A_out is bit-stable and in_ready=0 throughout. Then out_ready=1 with in_valid=1 → the new state is accepted that edge and out_valid drops next cycle.
- Reset asserted on the 3rd BUSY cycle (LPC=1) → next cycle st=IDLE, out_valid=0, in_ready=1, A_out all-zero. A new state accepted afterwards completes normally in 25 cycles.
- Random: 1000 random states, random pi_en, W∈{8,16,32,64}, LPC∈{1,5,25}, random out_ready → A_out matches a reference model of ρ/π with offsets mod W. There are no lost or duplicated outputs.
